// File: rtl/des_block_packer.sv
// des_block_packer
//   Turns the 16-bit PipeIn word stream into 64-bit DES input blocks.
//   Every four words form one block, with the first word in bits [15:0].
//   Completed blocks wait in a small first-word-fall-through FIFO until the
//   DES sequencer takes them over a valid/ready handshake.
//   The FIFO never stalls the pipe. If a block completes while the FIFO is
//   full and nothing is popped in that cycle, the block is dropped and the
//   sticky overflow flag is set.
//   Optional build macro DES_PACK_BYTESWAP_EN: when defined, the two bytes
//   of each incoming word are swapped before the word is stored.
module des_block_packer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk1,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  pipe_write,
  input  logic [15:0]           pipe_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [63:0]           blk_data,
  output logic [DEPTH_LOG2:0]   blk_count,
  output logic [1:0]            word_phase,
  output logic                  overflow
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_FULL = CNT_ONE << DEPTH_LOG2;

  logic [1:0]            phase_q;
  logic [47:0]           hold_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q;
  logic [DEPTH_LOG2:0]   rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;
  logic [63:0]           mem_q [DEPTH];

  logic [15:0]           word_in;
  logic [63:0]           blk_new;
  logic                  complete;
  logic                  pop;
  logic                  push;

  // Word as it enters the block, optionally byte-swapped for big-endian hosts.
`ifdef DES_PACK_BYTESWAP_EN
  assign word_in = {pipe_data[7:0], pipe_data[15:8]};
`else
  assign word_in = pipe_data;
`endif

  // Decide whether a block completes, is popped, or is pushed this cycle.
  // A full FIFO still takes a new block when a pop frees a slot in the same cycle.
  always_comb begin
    blk_new  = {word_in, hold_q};
    complete = pipe_write && (phase_q == 2'd3);
    pop      = (count_q != '0) && blk_ready;
    push     = complete && ((count_q != CNT_FULL) || pop);
  end

  // Assembler: phase counter and holding register for words 0..2.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 2'd0;
      hold_q  <= 48'd0;
    end else if (flush) begin
      phase_q <= 2'd0;
    end else if (pipe_write) begin
      phase_q <= phase_q + 2'd1;
      case (phase_q)
        2'd0:    hold_q[15:0]  <= word_in;
        2'd1:    hold_q[31:16] <= word_in;
        2'd2:    hold_q[47:32] <= word_in;
        default: hold_q        <= hold_q;
      endcase
    end
  end

  // FIFO storage. It has no reset because its contents are ignored while the count is zero.
  always_ff @(posedge clk1) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= blk_new;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CNT_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + CNT_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (complete && !push) ovf_q <= 1'b1;
    end
  end

  assign blk_valid  = (count_q != '0);
  assign blk_data   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign blk_count  = count_q;
  assign word_phase = phase_q;
  assign overflow   = ovf_q;

endmodule
